// File: rtl/clk_tick_monitor.sv
// -----------------------------------------------------------------------------
// clk_tick_monitor
//
// Receiving end of a clock divider output (dclk, segclk, clk_30hz style).
// The divided clock is treated as plain data: it is synchronised into the
// master clk domain and turned into single-cycle rise/fall strobes. Downstream
// logic can then run on clk with enables instead of on a derived clock. The
// block also measures the rise-to-rise period in clk cycles and flags dividers
// that are too fast, too slow or stalled.
//
// Optional feature (macro CLK_TICK_MONITOR_DUTY_EN):
//   When the macro is defined, an extra output high_time reports the length of
//   the last complete high phase of div_in, in clk cycles. When it is
//   undefined, that port and its counter do not exist. Nothing else changes.
//
// Parameters:
//   CNT_W        width of the period counter and of period / high_time
//   SYNC_STAGES  synchroniser flops on div_in (minimum 2)
//   MIN_PERIOD   smallest legal period in clk cycles
//   MAX_PERIOD   largest legal period in clk cycles (< 2**CNT_W - 1)
//
// Ports:
//   clk           in   master clock
//   clr           in   asynchronous active-high reset
//   div_in        in   divided clock under observation (asynchronous)
//   err_clr       in   synchronous clear of the sticky error flags
//   tick          out  one-cycle pulse per div_in rising edge
//   fall_tick     out  one-cycle pulse per div_in falling edge
//   period        out  last complete rise-to-rise period [CNT_W]
//   period_valid  out  period holds a valid measurement
//   too_fast      out  sticky: a measured period was below MIN_PERIOD
//   too_slow      out  sticky: a period exceeded MAX_PERIOD, or a stall
//   lost          out  no rising edge for more than MAX_PERIOD cycles
//   high_time     out  last complete high phase [CNT_W] (duty option only)
//
// Timing: div_in high sampled at clk edge N gives tick high after edge
// N+SYNC_STAGES+1. The period counter and FSM act on the same internal
// strobe that drives tick, so cnt is 1 in the cycle where tick is high.
// -----------------------------------------------------------------------------
module clk_tick_monitor #(
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PERIOD  = 4,
   parameter int MAX_PERIOD  = 3333400
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             div_in,
   input  logic             err_clr,
   output logic             tick,
   output logic             fall_tick,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             too_fast,
   output logic             too_slow,
`ifdef CLK_TICK_MONITOR_DUTY_EN
   output logic             lost,
   output logic [CNT_W-1:0] high_time
`else
   output logic             lost
`endif
);

   // --------------------------------------------------------------------------
   // Constants
   // --------------------------------------------------------------------------
   localparam int WARM_W = $clog2(SYNC_STAGES + 2);

   localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0]  MAX_P     = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0]  MAX_P1    = CNT_W'(MAX_PERIOD + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

   // FSM encoding
   localparam logic [1:0] ST_ACQUIRE = 2'd0;  // no rising edge seen yet
   localparam logic [1:0] ST_RUN     = 2'd1;  // measuring rise-to-rise
   localparam logic [1:0] ST_STALL   = 2'd2;  // divider stopped, waiting

   // --------------------------------------------------------------------------
   // Synchroniser, edge register and warm-up
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   e_q;
   logic [WARM_W-1:0]      warm_q;
   logic                   rise_q;   // internal rise strobe, drives FSM
   logic                   fall_q;   // internal fall strobe

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_q    <= '0;
         e_q       <= 1'b0;
         warm_q    <= WARM_INIT;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         tick      <= 1'b0;
         fall_tick <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
         // e always follows s; during warm-up it simply settles onto the
         // input level so a div_in that was high through reset is not
         // mistaken for a rising edge.
         e_q <= s;
         if (warm_q != '0) begin
            warm_q <= warm_q - 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            rise_q <= s & ~e_q;
            fall_q <= ~s & e_q;
         end
         tick      <= rise_q;
         fall_tick <= fall_q;
      end
   end

   // --------------------------------------------------------------------------
   // Period counter and FSM
   // --------------------------------------------------------------------------
   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             set_fast;
   logic             set_slow;
   logic             stall_now;

   // Saturating increment keeps cnt pinned at all-ones during a long stall.
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

   // A rise in the cycle where cnt holds MAX_PERIOD+1 is still a rise: the
   // period is reported (and flagged too slow) rather than declared a stall.
   always_comb begin
      set_fast  = 1'b0;
      set_slow  = 1'b0;
      stall_now = 1'b0;
      if (state_q == ST_RUN) begin
         if (rise_q) begin
            set_fast = (cnt_q < MIN_P);
            set_slow = (cnt_q > MAX_P);
         end else if (cnt_q >= MAX_P1) begin
            stall_now = 1'b1;
            set_slow  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_ACQUIRE;
         cnt_q        <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         too_fast     <= 1'b0;
         too_slow     <= 1'b0;
         lost         <= 1'b0;
      end else begin
         // Sticky flags: a new violation in the err_clr cycle wins.
         too_fast <= set_fast | (too_fast & ~err_clr);
         too_slow <= set_slow | (too_slow & ~err_clr);

         case (state_q)
            ST_ACQUIRE: begin
               // First edge only starts the interval; nothing to report yet.
               if (rise_q) begin
                  state_q <= ST_RUN;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q <= '0;
               end
            end

            ST_RUN: begin
               if (rise_q) begin
                  period       <= cnt_q;
                  period_valid <= 1'b1;
                  cnt_q        <= CNT_ONE;
               end else if (stall_now) begin
                  state_q      <= ST_STALL;
                  lost         <= 1'b1;
                  period_valid <= 1'b0;
                  cnt_q        <= cnt_inc;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end

            ST_STALL: begin
               // The interval that ends here straddles the stall, so it is
               // discarded; period_valid returns after the next full one.
               if (rise_q) begin
                  state_q <= ST_RUN;
                  lost    <= 1'b0;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end

            default: begin
               state_q <= ST_ACQUIRE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

`ifdef CLK_TICK_MONITOR_DUTY_EN
   // --------------------------------------------------------------------------
   // High-phase counter. hi_lvl mirrors div_in aligned to the internal
   // strobes, so the count covers exactly the cycles between rise and fall.
   // --------------------------------------------------------------------------
   logic [CNT_W-1:0] hi_cnt_q;
   logic             hi_lvl_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hi_cnt_q  <= '0;
         hi_lvl_q  <= 1'b0;
         high_time <= '0;
      end else begin
         if (rise_q) begin
            hi_cnt_q <= CNT_ONE;
            hi_lvl_q <= 1'b1;
         end else begin
            if (hi_lvl_q && (hi_cnt_q != CNT_SAT)) begin
               hi_cnt_q <= hi_cnt_q + 1'b1;
            end
            if (fall_q) begin
               hi_lvl_q <= 1'b0;
               if (state_q == ST_RUN) begin
                  high_time <= hi_cnt_q;
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_clk_tick_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_tick_monitor
//
// Two monitors watch the same div_in: dut_a with MIN_PERIOD=4 and dut_b with
// MIN_PERIOD=8, both with MAX_PERIOD=20 and an 8-bit counter. A table of
// per-cycle vectors covers the period-4 stream; hand-written sequences cover
// reset warm-up, stall/recovery, the MAX_PERIOD+1 boundary and clr mid-run.
// -----------------------------------------------------------------------------
module tb_clk_tick_monitor;

   localparam int CW = 8;

   logic          clk;
   logic          clr;
   logic          div_in;
   logic          err_clr;

   logic          a_tick, a_fall_tick, a_period_valid, a_too_fast, a_too_slow, a_lost;
   logic [CW-1:0] a_period;
   logic          b_tick, b_fall_tick, b_period_valid, b_too_fast, b_too_slow, b_lost;
   logic [CW-1:0] b_period;
`ifdef CLK_TICK_MONITOR_DUTY_EN
   logic [CW-1:0] a_high_time;
   logic [CW-1:0] b_high_time;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_tick = 0;
   bit saw_tick = 0;
   bit saw_fall = 0;
   bit saw_lost = 0;

   // ---------------------------------------------------------------------------
   // DUTs
   // ---------------------------------------------------------------------------
   clk_tick_monitor #(.CNT_W(CW), .SYNC_STAGES(2), .MIN_PERIOD(4), .MAX_PERIOD(20)) dut_a (
      .clk(clk), .clr(clr), .div_in(div_in), .err_clr(err_clr),
      .tick(a_tick), .fall_tick(a_fall_tick), .period(a_period),
      .period_valid(a_period_valid), .too_fast(a_too_fast), .too_slow(a_too_slow),
`ifdef CLK_TICK_MONITOR_DUTY_EN
      .lost(a_lost), .high_time(a_high_time)
`else
      .lost(a_lost)
`endif
   );

   clk_tick_monitor #(.CNT_W(CW), .SYNC_STAGES(2), .MIN_PERIOD(8), .MAX_PERIOD(20)) dut_b (
      .clk(clk), .clr(clr), .div_in(div_in), .err_clr(err_clr),
      .tick(b_tick), .fall_tick(b_fall_tick), .period(b_period),
      .period_valid(b_period_valid), .too_fast(b_too_fast), .too_slow(b_too_slow),
`ifdef CLK_TICK_MONITOR_DUTY_EN
      .lost(b_lost), .high_time(b_high_time)
`else
      .lost(b_lost)
`endif
   );

   // ---------------------------------------------------------------------------
   // Clock and watchdog
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Driver / checker tasks
   // ---------------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (a_tick) begin
         last_tick = cyc;
         saw_tick  = 1'b1;
      end
      if (a_fall_tick) saw_fall = 1'b1;
      if (a_lost) saw_lost = 1'b1;
   endtask

   task automatic hold(input logic val, input int n);
      div_in = val;
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wave(input int hi, input int lo);
      hold(1'b1, hi);
      hold(1'b0, lo);
   endtask

   // ---------------------------------------------------------------------------
   // Vector table for the period-4 stream
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          d;
      logic          ec;
      logic          tick;
      logic          fall;
      logic [CW-1:0] per;
      logic          pv;
      logic          tf_a;
      logic          tf_b;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   int lost_at;

   initial begin
      // div_in is high for the two last cycles of every 4; before the table
      // it has been high for a long time. Rises of div_in sampled at index 2,
      // 6, 10, ... give tick at 5, 9, 13, ...; falls at 0, 4, ... give
      // fall_tick at 3, 7, .... The first tick only arms the counter, the
      // second (index 9) reports period 4. err_clr at 14 clears dut_b's
      // too_fast; err_clr at 17 coincides with a new violation, which wins.
      for (int i = 0; i < NV; i++) begin
         vecs[i].d    = ((i % 4) >= 2);
         vecs[i].ec   = (i == 14) || (i == 17);
         vecs[i].tick = ((i % 4) == 1) && (i >= 5);
         vecs[i].fall = ((i % 4) == 3);
         vecs[i].per  = (i >= 9) ? CW'(4) : CW'(0);
         vecs[i].pv   = (i >= 9);
         vecs[i].tf_a = 1'b0;
         vecs[i].tf_b = (i >= 9) && !((i >= 14) && (i <= 16));
      end

      // ---- reset with div_in held high --------------------------------------
      clr     = 1'b1;
      div_in  = 1'b1;
      err_clr = 1'b0;
      repeat (3) step();
      chk("rst_tick",   a_tick, 0);
      chk("rst_fall",   a_fall_tick, 0);
      chk("rst_period", a_period, 0);
      chk("rst_pv",     a_period_valid, 0);
      chk("rst_fast",   a_too_fast, 0);
      chk("rst_slow",   a_too_slow, 0);
      chk("rst_lost",   a_lost, 0);

      clr      = 1'b0;
      saw_tick = 1'b0;
      saw_fall = 1'b0;
      saw_lost = 1'b0;
      hold(1'b1, 8);
      chk("warm_no_tick", saw_tick, 0);
      chk("warm_no_fall", saw_fall, 0);
      chk("warm_period",  a_period, 0);
      chk("warm_pv",      a_period_valid, 0);
      chk("warm_lost",    a_lost, 0);

      // ---- period-4 stream ---------------------------------------------------
      for (int i = 0; i < NV; i++) begin
         div_in  = vecs[i].d;
         err_clr = vecs[i].ec;
         step();
         chk($sformatf("v%0d_tick", i),   a_tick, vecs[i].tick);
         chk($sformatf("v%0d_fall", i),   a_fall_tick, vecs[i].fall);
         chk($sformatf("v%0d_period", i), a_period, vecs[i].per);
         chk($sformatf("v%0d_pv", i),     a_period_valid, vecs[i].pv);
         chk($sformatf("v%0d_fast_a", i), a_too_fast, vecs[i].tf_a);
         chk($sformatf("v%0d_fast_b", i), b_too_fast, vecs[i].tf_b);
         chk($sformatf("v%0d_slow", i),   a_too_slow, 0);
         chk($sformatf("v%0d_lost", i),   a_lost, 0);
      end
      err_clr = 1'b0;

      // ---- period 10, then stall ---------------------------------------------
      hold(1'b0, 10);
      repeat (4) wave(5, 5);
      chk("p10_period", a_period, 10);
      chk("p10_pv",     a_period_valid, 1);
      chk("p10_slow",   a_too_slow, 0);
      chk("p10_lost",   a_lost, 0);
      chk("p10_fast_a", a_too_fast, 0);

      lost_at = 0;
      div_in  = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (a_lost && (lost_at == 0)) lost_at = cyc - last_tick;
      end
      chk("stall_latency", lost_at, 21);
      chk("stall_lost",    a_lost, 1);
      chk("stall_slow",    a_too_slow, 1);
      chk("stall_pv",      a_period_valid, 0);
      chk("stall_period",  a_period, 10);

      // err_clr with the input stopped: sticky flags clear, lost does not.
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("eclr_slow_a", a_too_slow, 0);
      chk("eclr_slow_b", b_too_slow, 0);
      chk("eclr_fast_b", b_too_fast, 0);
      chk("eclr_lost",   a_lost, 1);
      chk("eclr_period", a_period, 10);
      chk("eclr_pv",     a_period_valid, 0);

      // Resume: first rise only clears lost, the next one reports.
      wave(5, 5);
      chk("res1_lost",   a_lost, 0);
      chk("res1_pv",     a_period_valid, 0);
      chk("res1_period", a_period, 10);
      wave(5, 5);
      chk("res2_pv",     a_period_valid, 1);
      chk("res2_period", a_period, 10);
      chk("res2_slow",   a_too_slow, 0);

      // ---- rise exactly MAX_PERIOD+1 after the previous one ------------------
      saw_lost = 1'b0;
      wave(5, 16);
      chk("bnd_prev_period", a_period, 10);
      chk("bnd_prev_slow",   a_too_slow, 0);
      wave(5, 5);
      chk("bnd_period",   a_period, 21);
      chk("bnd_slow",     a_too_slow, 1);
      chk("bnd_lost",     a_lost, 0);
      chk("bnd_saw_lost", saw_lost, 0);
      chk("bnd_pv",       a_period_valid, 1);
      chk("bnd_fast",     a_too_fast, 0);

      // ---- clr in the middle of a measurement --------------------------------
      hold(1'b1, 3);
      #2;
      clr = 1'b1;
      #1;
      chk("aclr_period", a_period, 0);
      chk("aclr_pv",     a_period_valid, 0);
      chk("aclr_slow",   a_too_slow, 0);
      chk("aclr_lost",   a_lost, 0);
      chk("aclr_tick",   a_tick, 0);
      step();
      step();
      div_in = 1'b0;
      clr    = 1'b0;
      hold(1'b0, 5);
      wave(5, 5);
      chk("post_clr1_period", a_period, 0);
      chk("post_clr1_pv",     a_period_valid, 0);
      wave(5, 5);
      chk("post_clr2_period", a_period, 10);
      chk("post_clr2_pv",     a_period_valid, 1);

`ifdef CLK_TICK_MONITOR_DUTY_EN
      // ---- duty: high 3 / low 7 ----------------------------------------------
      wave(3, 7);
      wave(3, 7);
      chk("duty_high_time", a_high_time, 3);
      chk("duty_period",    a_period, 10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
